vga_timing_gen: RTL and testbench

- Raster timing generator that drives the VGA_Timing bundle consumed by the video controller's timing_i.
- Divides the system clock into pixel ticks and runs horizontal and vertical counters.
- Produces sync, blanking and the single-tick line/frame strobes that the controller uses to schedule SDRAM line fetches and line-buffer scan-out.
- Sits at the head of the video pipeline. Its output passes through the video controller to the DAC/encoder.

---
 rtl/vga_timing_gen.sv | 171 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-tick divider, h/v counters and a registered sync/blank/strobe bundle.
// Optional line-compare interrupt (line_cmp_i/line_irq_o) when VGA_TIMING_LINE_IRQ_EN is defined.
package vga_timing_pkg;

  typedef struct packed {
    logic valid;
    logic blank_n;
    logic hsync_n;
    logic vsync_n;
    logic end_of_line;
    logic end_of_visible_line;
    logic next_line_visible;
    logic end_of_frame;
  } vga_timing_t;

  localparam vga_timing_t TIMING_RST = '{
    valid:               1'b0,
    blank_n:             1'b0,
    hsync_n:             1'b1,
    vsync_n:             1'b1,
    end_of_line:         1'b0,
    end_of_visible_line: 1'b0,
    next_line_visible:   1'b0,
    end_of_frame:        1'b0
  };

endpackage

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
`ifdef VGA_TIMING_LINE_IRQ_EN
  input  logic [9:0]  line_cmp_i,
  output logic        line_irq_o,
`endif
  output vga_timing_t timing_o,
  output logic [10:0] h_o,
  output logic [9:0]  v_o
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0]      H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0]      H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0]      H_VIS_LAST = 11'(H_VISIBLE - 1);
  localparam logic [10:0]      HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0]      HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]       V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]       V_VIS      = 10'(V_VISIBLE);
  localparam logic [10:0]      V_VIS_X    = 11'(V_VISIBLE);
  localparam logic [9:0]       VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]       VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic             V_VIS_NZ   = (V_VISIBLE > 0);

  if (CLK_DIV < 1 || H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_param_err
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      h_q, h_d;
  logic [9:0]       v_q, v_d;
  vga_timing_t      timing_q, timing_d;
  logic [10:0]      h_out_q, h_out_d;
  logic [9:0]       v_out_q, v_out_d;
  logic             tick;
  logic             h_last;
  logic             v_last;

  assign tick   = en_i && (div_q == DIV_LAST);
  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  // Raster counters: divider always runs while enabled, h/v advance on pixel ticks.
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (en_i) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        h_d = h_last ? '0 : h_q + 11'd1;
        if (h_last) begin
          v_d = v_last ? '0 : v_q + 10'd1;
        end
      end
    end
  end

  // Output bundle: levels and position update on ticks only, strobes are single-cycle.
  always_comb begin
    timing_d                     = timing_q;
    timing_d.valid               = 1'b0;
    timing_d.end_of_line         = 1'b0;
    timing_d.end_of_visible_line = 1'b0;
    timing_d.next_line_visible   = 1'b0;
    timing_d.end_of_frame        = 1'b0;
    h_out_d                      = h_out_q;
    v_out_d                      = v_out_q;
    if (tick) begin
      timing_d.valid               = 1'b1;
      timing_d.blank_n             = (h_q < H_VIS) && (v_q < V_VIS);
      timing_d.hsync_n             = !((h_q >= HS_START) && (h_q < HS_END));
      timing_d.vsync_n             = !((v_q >= VS_START) && (v_q < VS_END));
      timing_d.end_of_line         = h_last;
      timing_d.end_of_visible_line = (h_q == H_VIS_LAST) && (v_q < V_VIS);
      timing_d.next_line_visible   = h_last &&
                                     (v_last ? V_VIS_NZ : ((11'(v_q) + 11'd1) < V_VIS_X));
      timing_d.end_of_frame        = h_last && v_last;
      h_out_d                      = h_q;
      v_out_d                      = v_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      timing_q <= TIMING_RST;
      h_out_q  <= '0;
      v_out_q  <= '0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      timing_q <= timing_d;
      h_out_q  <= h_out_d;
      v_out_q  <= v_out_d;
    end
  end

  assign timing_o = timing_q;
  assign h_o      = h_out_q;
  assign v_o      = v_out_q;

`ifdef VGA_TIMING_LINE_IRQ_EN
  logic irq_q, irq_d;

  // Out-of-range compare values never match since v stays below V_TOTAL.
  assign irq_d = tick && h_last && (v_q == line_cmp_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign line_irq_o = irq_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with a small 14x7 raster (CLK_DIV=2).
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic        en_i;
  vga_timing_t timing_o;
  logic [10:0] h_o;
  logic [9:0]  v_o;
`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [9:0]  line_cmp_i;
  logic        line_irq_o;
`endif

  int n_tests;
  int n_fail;

  // {valid, blank_n, hsync_n, vsync_n, eol, eovl, nlv, eof}
  localparam logic [7:0] T_RST = 8'b0011_0000;

  vga_timing_gen #(
    .CLK_DIV  (2),
    .H_VISIBLE(8),
    .H_FRONT  (2),
    .H_SYNC   (2),
    .H_BACK   (2),
    .V_VISIBLE(4),
    .V_FRONT  (1),
    .V_SYNC   (1),
    .V_BACK   (1)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .line_cmp_i(line_cmp_i),
    .line_irq_o(line_irq_o),
`endif
    .timing_o  (timing_o),
    .h_o       (h_o),
    .v_o       (v_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        en;
    logic [7:0]  exp_t;
    logic [10:0] exp_h;
    logic [9:0]  exp_v;
  } vec_t;

  vec_t vecs[15];

  // Model-driven run from a fresh reset release with en_i=1; checks every cycle.
  task automatic run_frame(input int ncyc, output int n_valid, output int n_eol,
                           output int n_eovl, output int n_eof, output int first_eof,
                           output int n_irq);
    int         mdiv, mh, mv, eh, ev;
    logic       tick, lb, lhs, lvs;
    logic       e_eol, e_eovl, e_nlv, e_eof;
    logic [7:0] exp_t;
    logic [7:0] act_t;
`ifdef VGA_TIMING_LINE_IRQ_EN
    logic       e_irq;
`endif
    mdiv = 0; mh = 0; mv = 0; eh = 0; ev = 0;
    lb = 1'b0; lhs = 1'b1; lvs = 1'b1;
    n_valid = 0; n_eol = 0; n_eovl = 0; n_eof = 0; first_eof = -1; n_irq = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk_i);
      tick = (mdiv == 1);
      e_eol = 1'b0; e_eovl = 1'b0; e_nlv = 1'b0; e_eof = 1'b0;
`ifdef VGA_TIMING_LINE_IRQ_EN
      e_irq = tick && (mh == 13) && (32'(mv) == 32'(line_cmp_i));
`endif
      if (tick) begin
        lb     = (mh < 8) && (mv < 4);
        lhs    = !((mh == 10) || (mh == 11));
        lvs    = (mv != 5);
        e_eol  = (mh == 13);
        e_eovl = (mh == 7) && (mv < 4);
        e_nlv  = (mh == 13) && ((mv == 6) || (mv <= 2));
        e_eof  = (mh == 13) && (mv == 6);
        eh = mh; ev = mv;
        if (mh == 13) begin
          mh = 0;
          mv = (mv == 6) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
      mdiv = (mdiv + 1) % 2;
      exp_t = {tick, lb, lhs, lvs, e_eol, e_eovl, e_nlv, e_eof};
      @(negedge clk_i);
      act_t = timing_o;
      chk($sformatf("frame_c%0d_timing", c), 32'(act_t), 32'(exp_t));
      chk($sformatf("frame_c%0d_h", c), 32'(h_o), 32'(eh));
      chk($sformatf("frame_c%0d_v", c), 32'(v_o), 32'(ev));
`ifdef VGA_TIMING_LINE_IRQ_EN
      chk($sformatf("frame_c%0d_irq", c), 32'(line_irq_o), 32'(e_irq));
      if (line_irq_o) n_irq++;
`endif
      if (timing_o.valid) n_valid++;
      if (timing_o.end_of_line) n_eol++;
      if (timing_o.end_of_visible_line) n_eovl++;
      if (timing_o.end_of_frame) begin
        n_eof++;
        if (first_eof < 0) first_eof = c;
      end
    end
  endtask

  task automatic sync_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int         nv, ne, nev, nf, ff, ni;
    logic [7:0] act_t;
    n_tests = 0;
    n_fail  = 0;
    rst_ni  = 1'b0;
    en_i    = 1'b0;
`ifdef VGA_TIMING_LINE_IRQ_EN
    line_cmp_i = 10'd2;
`endif

    vecs[0]  = '{1'b1, 8'b0011_0000, 11'd0, 10'd0};
    vecs[1]  = '{1'b1, 8'b1111_0000, 11'd0, 10'd0};
    vecs[2]  = '{1'b1, 8'b0111_0000, 11'd0, 10'd0};
    vecs[3]  = '{1'b1, 8'b1111_0000, 11'd1, 10'd0};
    vecs[4]  = '{1'b1, 8'b0111_0000, 11'd1, 10'd0};
    vecs[5]  = '{1'b1, 8'b1111_0000, 11'd2, 10'd0};
    vecs[6]  = '{1'b1, 8'b0111_0000, 11'd2, 10'd0};
    vecs[7]  = '{1'b1, 8'b1111_0000, 11'd3, 10'd0};
    vecs[8]  = '{1'b0, 8'b0111_0000, 11'd3, 10'd0};
    vecs[9]  = '{1'b0, 8'b0111_0000, 11'd3, 10'd0};
    vecs[10] = '{1'b0, 8'b0111_0000, 11'd3, 10'd0};
    vecs[11] = '{1'b0, 8'b0111_0000, 11'd3, 10'd0};
    vecs[12] = '{1'b0, 8'b0111_0000, 11'd3, 10'd0};
    vecs[13] = '{1'b1, 8'b0111_0000, 11'd3, 10'd0};
    vecs[14] = '{1'b1, 8'b1111_0000, 11'd4, 10'd0};

    repeat (3) @(negedge clk_i);
    act_t = timing_o;
    chk("reset_timing", 32'(act_t), 32'(T_RST));
    chk("reset_h", 32'(h_o), 32'd0);
    chk("reset_v", 32'(v_o), 32'd0);
`ifdef VGA_TIMING_LINE_IRQ_EN
    chk("reset_irq", 32'(line_irq_o), 32'd0);
`endif

    // Reset exit, pixel cadence and a 5-cycle en_i stall at h=3.
    rst_ni = 1'b1;
    for (int i = 0; i < 15; i++) begin
      en_i = vecs[i].en;
      @(posedge clk_i);
      @(negedge clk_i);
      act_t = timing_o;
      chk($sformatf("vec%0d_timing", i), 32'(act_t), 32'(vecs[i].exp_t));
      chk($sformatf("vec%0d_h", i), 32'(h_o), 32'(vecs[i].exp_h));
      chk($sformatf("vec%0d_v", i), 32'(v_o), 32'(vecs[i].exp_v));
    end

    // Two full frames from reset.
    en_i = 1'b1;
    sync_reset();
    run_frame(392, nv, ne, nev, nf, ff, ni);
    chk("2f_valid_cnt", 32'(nv), 32'd196);
    chk("2f_eol_cnt", 32'(ne), 32'd14);
    chk("2f_eovl_cnt", 32'(nev), 32'd8);
    chk("2f_eof_cnt", 32'(nf), 32'd2);
    chk("2f_first_eof", 32'(ff), 32'd196);
`ifdef VGA_TIMING_LINE_IRQ_EN
    chk("2f_irq_cnt", 32'(ni), 32'd2);
`endif

    // Asynchronous reset mid-frame at (h=9, v=2).
    sync_reset();
    run_frame(76, nv, ne, nev, nf, ff, ni);
    chk("pre_async_h", 32'(h_o), 32'd9);
    chk("pre_async_v", 32'(v_o), 32'd2);
    #1 rst_ni = 1'b0;
    #1;
    act_t = timing_o;
    chk("async_rst_timing", 32'(act_t), 32'(T_RST));
    chk("async_rst_h", 32'(h_o), 32'd0);
    chk("async_rst_v", 32'(v_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
`ifdef VGA_TIMING_LINE_IRQ_EN
    line_cmp_i = 10'd9;
`endif
    run_frame(196, nv, ne, nev, nf, ff, ni);
    chk("1f_valid_cnt", 32'(nv), 32'd98);
    chk("1f_eol_cnt", 32'(ne), 32'd7);
    chk("1f_eovl_cnt", 32'(nev), 32'd4);
    chk("1f_eof_cnt", 32'(nf), 32'd1);
    chk("1f_first_eof", 32'(ff), 32'd196);
`ifdef VGA_TIMING_LINE_IRQ_EN
    chk("1f_irq_cnt_cmp9", 32'(ni), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
